// File: rtl/adder_stream_pkg.sv
// Shared types and helpers for the chunked streaming adder.
// Payload fields are sized to MAX_W so one type serves any WIDTH.
package adder_stream_pkg;

  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] lo_sum;
    logic [MAX_W-1:0] hi_a;
    logic [MAX_W-1:0] hi_b;
    logic             carry;
    logic             valid;
  } stage_pl_t;

  function automatic int chunk_w(int w, int s);
    return (s < 1) ? w : w / s;
  endfunction

  function automatic bit params_ok(int w, int s);
    if (s < 1 || w < 1 || w > MAX_W) return 1'b0;
    return (w % s) == 0;
  endfunction

endpackage

// File: rtl/adder_chunk_stage.sv
// One CW-bit slice of the adder plus its payload register.
// Operands shift down so the live chunk always sits at bit 0.
module adder_chunk_stage
  import adder_stream_pkg::*;
#(
  parameter int CW = 8,
  parameter int W  = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      en,
  input  stage_pl_t d,
  output stage_pl_t q
);

  logic [CW:0] add;
  stage_pl_t   nxt;

  // chunk add with the carry handed over from the previous slice
  always_comb begin
    add = {1'b0, d.hi_a[CW-1:0]}
        + {1'b0, d.hi_b[CW-1:0]}
        + (CW+1)'(d.carry);
  end

  // new sum bits enter at the top; lower sum drifts down
  always_comb begin
    nxt        = d;
    nxt.lo_sum = (d.lo_sum >> CW)
               | (MAX_W'(add[CW-1:0]) << (W - CW));
    nxt.hi_a   = d.hi_a >> CW;
    nxt.hi_b   = d.hi_b >> CW;
    nxt.carry  = add[CW];
  end

  // payload register, frozen while the pipe stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/adder_stream_pipe.sv
// Valid/ready streaming adder split into STAGES carry-registered slices.
// The stall is global: every slice holds when the output is blocked.
module adder_stream_pipe
  import adder_stream_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [CNT_W-1:0] txn_count
);

  localparam int CW = chunk_w(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $fatal(1, "adder_stream_pipe: bad WIDTH/STAGES");
  end

  stage_pl_t                stage_in;
  stage_pl_t [STAGES-1:0]   stage_q;
  logic                     advance;
  logic                     unused_tail;

  assign out_valid   = stage_q[STAGES-1].valid;
  assign advance     = !out_valid || out_ready;
  assign in_ready    = advance;
  assign out_sum     = stage_q[STAGES-1].lo_sum[WIDTH-1:0];
  assign out_cout    = stage_q[STAGES-1].carry;
  assign unused_tail = ^stage_q[STAGES-1];

  // slice 0 payload straight from the input port
  always_comb begin
    stage_in       = '0;
    stage_in.hi_a  = MAX_W'(in_a);
    stage_in.hi_b  = MAX_W'(in_b);
    stage_in.carry = in_cin;
    stage_in.valid = in_valid && in_ready;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_pl_t d_k;
    if (k == 0) begin : g_first
      assign d_k = stage_in;
    end else begin : g_next
      assign d_k = stage_q[k-1];
    end
    adder_chunk_stage #(
      .CW (CW),
      .W  (WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .d     (d_k),
      .q     (stage_q[k])
    );
  end

  // completed output handshakes, wrapping silently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else if (out_valid && out_ready) begin
      txn_count <= txn_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_adder_stream_pipe.sv
// Directed scoreboard bench for adder_stream_pipe.
// Expected sums are queued at accept and popped at emit.
module tb_adder_stream_pipe;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [CNT_W-1:0] txn_count;

  typedef struct {
    logic [WIDTH:0] res;
    int             t;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               errors = 0;
  int               cyc_n = 0;
  logic [CNT_W-1:0] cnt_m = '0;
  bit               chk_lat = 1'b1;

  adder_stream_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .txn_count (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(string tag,
                       logic [63:0] obs,
                       logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // one clock: sample handshakes before the edge, audit after
  task automatic step();
    exp_t e;
    #1;
    if (in_valid && in_ready) begin
      e.res = {1'b0, in_a} + {1'b0, in_b}
            + (WIDTH+1)'(in_cin);
      e.t   = cyc_n;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("sum", out_sum, e.res[WIDTH-1:0]);
        check("cout", out_cout, e.res[WIDTH]);
        if (chk_lat)
          check("latency", cyc_n - e.t, STAGES);
        cnt_m++;
      end
    end
    @(posedge clk);
    cyc_n++;
    #1 check("txn_count", txn_count, cnt_m);
    @(negedge clk);
  endtask

  task automatic send(logic [WIDTH-1:0] a,
                      logic [WIDTH-1:0] b,
                      logic c);
    in_a     = a;
    in_b     = b;
    in_cin   = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (sb.size() != 0 && n < 40) begin
      step();
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    // 1: reset state
    repeat (2) @(negedge clk);
    #1 check("rst_out_valid", out_valid, 0);
    check("rst_count", txn_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 check("rst_in_ready", in_ready, 1);
    check("rst_valid2", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_cout", out_cout, 0);
    check("rst_count2", txn_count, 0);
    @(negedge clk);

    // 2: single transaction
    out_ready = 1'b1;
    send(32'h0000_00FF, 32'h0000_0001, 1'b0);
    drain();
    check("t2_count", txn_count, 1);

    // 3: full-width carry ripple
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();

    // 4: back-to-back stream
    for (int i = 0; i < 8; i++)
      send(WIDTH'(i), WIDTH'(16 * i), 1'b0);
    drain();
    check("t4_count", txn_count, 11);

    // 5: backpressure with a full pipe
    chk_lat   = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(WIDTH'(32'h1000 + i),
           WIDTH'(32'h2_0000 * i), i[0]);
    check("t5_inflight", sb.size(), 4);
    for (int j = 0; j < 3; j++) begin
      in_a     = WIDTH'(32'hDEAD_0000 + j);
      in_b     = 32'h1;
      in_valid = 1'b1;
      #1 check("t5_in_ready", in_ready, 0);
      check("t5_out_valid", out_valid, 1);
      if (sb.size() != 0)
        check("t5_hold", out_sum, sb[0].res[WIDTH-1:0]);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    check("t5_count", txn_count, 15);

    // 6: reset with transactions in flight
    chk_lat = 1'b1;
    for (int i = 0; i < 3; i++)
      send(WIDTH'(32'h55 + i), 32'h100, 1'b0);
    rst_n = 1'b0;
    #1 check("t6_out_valid", out_valid, 0);
    check("t6_count", txn_count, 0);
    sb.delete();
    cnt_m = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step();
    send(32'h1234_5678, 32'h1111_1111, 1'b1);
    drain();
    check("t6_count_after", txn_count, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
